// File: rtl/alu_drv_pkg.sv
// Shared types and constants for the ap_ctrl_hs initiator (alu_ap_driver).
package alu_drv_pkg;

    localparam int unsigned DRV_DATA_W = 32;
    localparam int unsigned WDOG_W     = 16;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESULT
    } drv_state_t;

endpackage

// File: rtl/alu_ap_driver_if.sv
// Operand/result streams plus the ap_ctrl_hs core bus of one calculate_N instance.
interface alu_ap_driver_if #(
    parameter int unsigned DATA_W = alu_drv_pkg::DRV_DATA_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_timeout;
    logic              ap_start;
    logic              ap_done;
    logic              ap_idle;
    logic              ap_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] ap_return;

    modport master (
        input  in_valid, in_a, in_b, out_ready, ap_done, ap_idle, ap_ready, ap_return,
        output in_ready, out_valid, out_data, out_timeout, ap_start, a, b
    );

    modport slave (
        output in_valid, in_a, in_b, out_ready, ap_done, ap_idle, ap_ready, ap_return,
        input  in_ready, out_valid, out_data, out_timeout, ap_start, a, b
    );
endinterface

// File: rtl/alu_drv_watchdog.sv
// Cycle counter for START+WAIT; expired flags the TIMEOUT_CYC-th cycle of a transaction.
module alu_drv_watchdog
    import alu_drv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT_CYC - 1);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;

    // Saturates at LAST so a stalled transaction keeps expired asserted.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + WDOG_W'(1);
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/alu_ap_driver.sv
// ap_ctrl_hs initiator: operand stream in, one core driven, result stream out.
// Optional watchdog abort enabled by defining ALU_DRV_TIMEOUT_EN.
module alu_ap_driver
    import alu_drv_pkg::*;
#(
    parameter int unsigned DATA_W      = DRV_DATA_W,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    alu_ap_driver_if.master  bus
);
    drv_state_t        state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              tmo_q, tmo_d;
    logic              done_seen_q, done_seen_d;
    logic              ap_start_q, ap_start_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              got;
    logic              expired;

`ifdef ALU_DRV_TIMEOUT_EN
    logic wd_active;

    assign wd_active = (state_q == START) || (state_q == WAIT);

    alu_drv_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .clear    (!wd_active),
        .enable   (wd_active),
        .expired  (expired)
    );
`else
    assign expired = 1'b0;
`endif

    // Next state and next register values; a done seen during START is kept
    // so the later ap_ready completes the handshake without a second capture.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        tmo_d       = tmo_q;
        done_seen_d = done_seen_q;
        got         = done_seen_q | bus.ap_done;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d         = bus.in_a;
                    b_d         = bus.in_b;
                    tmo_d       = 1'b0;
                    done_seen_d = 1'b0;
                    state_d     = START;
                end
            end
            START: begin
                if (bus.ap_done && !done_seen_q) begin
                    res_d       = bus.ap_return;
                    done_seen_d = 1'b1;
                end
                if (expired && !got) begin
                    res_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = RESULT;
                end else if (got && (bus.ap_ready || expired)) begin
                    state_d = RESULT;
                end else if (bus.ap_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.ap_done) begin
                    res_d   = bus.ap_return;
                    state_d = RESULT;
                end else if (expired) begin
                    res_d   = '0;
                    tmo_d   = 1'b1;
                    state_d = RESULT;
                end
            end
            RESULT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        ap_start_d  = (state_d == START);
        out_valid_d = (state_d == RESULT);
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            tmo_q       <= 1'b0;
            done_seen_q <= 1'b0;
            ap_start_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            tmo_q       <= tmo_d;
            done_seen_q <= done_seen_d;
            ap_start_q  <= ap_start_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.ap_start    = ap_start_q;
    assign bus.a           = a_q;
    assign bus.b           = b_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = res_q;
    assign bus.out_timeout = tmo_q;

endmodule

// File: tb/tb_alu_ap_driver.sv
// Self-checking bench for alu_ap_driver with a configurable-latency core model.
module tb_alu_ap_driver;
    localparam int unsigned W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_ap_driver_if #(.DATA_W(W)) bus ();

    alu_ap_driver #(
        .DATA_W      (W),
        .TIMEOUT_CYC (8)
    ) dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus.master)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Core model: ap_ready at cycle R and ap_done at cycle D, counted from the first ap_start cycle.
    int   cfg_r = 0, cfg_d = 0;
    bit   use_rnd = 1'b0;
    bit   force_done = 1'b0;
    int   rnd_r = 0, rnd_d = 0;
    bit   run_q = 1'b0;
    int   k_q = 0;
    int   eff_r, eff_d, cur_k, cur_max;
    logic cur_act;

    always_comb begin
        eff_r         = use_rnd ? rnd_r : cfg_r;
        eff_d         = use_rnd ? rnd_d : cfg_d;
        cur_max       = (eff_r > eff_d) ? eff_r : eff_d;
        cur_act       = run_q || bus.ap_start;
        cur_k         = run_q ? k_q : 0;
        bus.ap_ready  = cur_act && (cur_k == eff_r);
        bus.ap_done   = (cur_act && (cur_k == eff_d)) || force_done;
        bus.ap_idle   = !cur_act;
        bus.ap_return = bus.ap_done ? (bus.a + bus.b) : 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            k_q   <= 0;
        end else if (cur_act) begin
            if (cur_k >= cur_max) begin
                run_q <= 1'b0;
                k_q   <= 0;
                if (use_rnd) begin
                    rnd_r <= int'($urandom_range(3, 0));
                    rnd_d <= int'($urandom_range(5, 0));
                end
            end else begin
                run_q <= 1'b1;
                k_q   <= cur_k + 1;
            end
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          r;
        int          d;
        logic [31:0] exp_data;
        int          exp_start;
        int          exp_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic do_reset();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One transaction: counts ap_start cycles and out_valid latency from the accept cycle.
    task automatic run_one(input string tag, input vec_t v, input logic exp_tmo);
        int          start_cnt = 0;
        int          lat = -1;
        logic [31:0] dat = '0;
        logic        tmo = 1'b0;
        cfg_r = v.r;
        cfg_d = v.d;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_a = v.a;
        bus.in_b = v.b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int t = 1; t <= 60 && lat < 0; t++) begin
            @(negedge clk);
            if (bus.ap_start) start_cnt++;
            if (bus.out_valid) begin
                lat = t;
                dat = bus.out_data;
                tmo = bus.out_timeout;
            end
        end
        check({tag, " start_cycles"}, 32'(start_cnt), 32'(v.exp_start));
        check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, " data"}, dat, v.exp_data);
        check({tag, " timeout"}, 32'(tmo), 32'(exp_tmo));
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    logic [31:0] sb[$];
    logic [31:0] exp_v;
    int          pushed, popped, viol;
    int          bad_rdy, bad_dat, bad_st, bad_v, cnt_v, cnt_s;
    logic        acc, seen;

    initial begin
        vecs[0] = '{a: 32'd5,          b: 32'd7,          r: 0, d: 0, exp_data: 32'd12,         exp_start: 1, exp_lat: 2};
        vecs[1] = '{a: 32'h1000_0000,  b: 32'h0000_0ABC,  r: 1, d: 4, exp_data: 32'h1000_0ABC,  exp_start: 2, exp_lat: 6};
        vecs[2] = '{a: 32'hFFFF_FFFF,  b: 32'd2,          r: 3, d: 1, exp_data: 32'd1,          exp_start: 4, exp_lat: 5};
        vecs[3] = '{a: 32'd100,        b: 32'd200,        r: 2, d: 2, exp_data: 32'd300,        exp_start: 3, exp_lat: 4};
        vecs[4] = '{a: 32'h7000_0000,  b: 32'h0000_1234,  r: 0, d: 3, exp_data: 32'h7000_1234,  exp_start: 1, exp_lat: 5};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst ap_start", 32'(bus.ap_start), 32'd0);
        check("rst out_data", bus.out_data, 32'd0);
        check("rst out_timeout", 32'(bus.out_timeout), 32'd0);
        check("rst a", bus.a, 32'd0);
        check("rst b", bus.b, 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i], 1'b0);
        end

        // Consumer stall with a new operand pair waiting.
        cfg_r = 0;
        cfg_d = 0;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_a = 32'd100;
        bus.in_b = 32'd23;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_a = 32'd1;
        bus.in_b = 32'd2;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("stall first valid", 32'(seen), 32'd1);
        bad_rdy = 0; bad_dat = 0; bad_st = 0; bad_v = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.in_ready) bad_rdy++;
            if (bus.out_data !== 32'd123) bad_dat++;
            if (bus.ap_start) bad_st++;
            if (!bus.out_valid) bad_v++;
        end
        check("stall in_ready cycles", 32'(bad_rdy), 32'd0);
        check("stall data changes", 32'(bad_dat), 32'd0);
        check("stall ap_start cycles", 32'(bad_st), 32'd0);
        check("stall valid drops", 32'(bad_v), 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 5 && !seen; t++) begin
            @(negedge clk);
            if (bus.in_ready) seen = 1'b1;
        end
        check("stall release in_ready", 32'(seen), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("stall second valid", 32'(seen), 32'd1);
        check("stall second data", bus.out_data, 32'd3);
        @(posedge clk); #1;

        // Core that never completes.
`ifdef ALU_DRV_TIMEOUT_EN
        begin
            vec_t tv;
            tv = '{a: 32'd9, b: 32'd9, r: 1000, d: 1000, exp_data: 32'd0, exp_start: 8, exp_lat: 9};
            run_one("timeout", tv, 1'b1);
        end
`else
        cfg_r = 1000;
        cfg_d = 1000;
        @(posedge clk); #1;
        bus.in_a = 32'd9;
        bus.in_b = 32'd9;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cnt_v = 0;
        cnt_s = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.out_valid) cnt_v++;
            if (bus.ap_start) cnt_s++;
        end
        check("no_timeout out_valid cycles", 32'(cnt_v), 32'd0);
        check("no_timeout ap_start cycles", 32'(cnt_s), 32'd1000);
`endif
        do_reset();

        // Reset while waiting for ap_done.
        cfg_r = 0;
        cfg_d = 20;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_a = 32'd4;
        bus.in_b = 32'd4;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("wait ap_start", 32'(bus.ap_start), 32'd0);
        check("wait in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst ap_start", 32'(bus.ap_start), 32'd0);
        check("midrst out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        force_done = 1'b1;
        @(posedge clk); #1;
        force_done = 1'b0;
        cnt_v = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.out_valid) cnt_v++;
        end
        check("stray done out_valid", 32'(cnt_v), 32'd0);
        check("stray done in_ready", 32'(bus.in_ready), 32'd1);

        // Random traffic against the scoreboard.
        use_rnd = 1'b1;
        pushed = 0;
        popped = 0;
        viol = 0;
        acc = 1'b0;
        for (int c = 0; c < 20000 && popped < 1000; c++) begin
            @(posedge clk); #1;
            if (!bus.in_valid || acc) begin
                if (pushed < 1000 && $urandom_range(3, 0) != 0) begin
                    bus.in_a = $urandom;
                    bus.in_b = $urandom;
                    bus.in_valid = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(3, 0) != 0);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (acc) begin
                sb.push_back(bus.in_a + bus.in_b);
                pushed++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rnd_pop: got result %0h expected no result", bus.out_data);
                end else begin
                    exp_v = sb.pop_front();
                    check("rnd data", bus.out_data, exp_v);
                    popped++;
                end
            end
            if (bus.ap_start && bus.out_valid) viol++;
        end
        bus.in_valid = 1'b0;
        check("rnd results", 32'(popped), 32'd1000);
        check("rnd start_while_valid", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_ap_driver.md
# alu_ap_driver

Initiator side of the ap_ctrl_hs block-level handshake used by the obfuscated `calculate_*` cores. Accepts operand pairs on a valid/ready stream and drives ap_start, a and b into one attached core. Captures ap_return on ap_done and presents the result on a valid/ready output stream. Sits between the system-side operand source and a `calculate_N` instance, and is the only agent that asserts that core's ap_start.

## Interface

- DATA_W, 32, operand and result width.
- TIMEOUT_CYC, 255, maximum cycles in START+WAIT before abort; used only with the watchdog macro. Legal range 1..65535.

- ap_clk  in  1  single clock; all logic on the rising edge.
- ap_rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  driver can accept an operand pair.
- in_a  in  DATA_W  operand a.
- in_b  in  DATA_W  operand b.
- out_valid  out  1  result held for the consumer.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  captured ap_return, or 0 on timeout.
- out_timeout  out  1  result is an aborted transaction; qualified by out_valid.
- ap_start  out  1  to core.
- ap_done  in  1  from core.
- ap_idle  in  1  from core; status only, no effect on sequencing.
- ap_ready  in  1  from core.
- a  out  DATA_W  to core, registered.
- b  out  DATA_W  to core, registered.
- ap_return  in  DATA_W  from core.

## Operation

- FSM states: IDLE, START, WAIT, RESULT.
- IDLE:
  - in_ready=1.
  - When in_valid is high: register in_a/in_b into a/b, then go to START.
- START:
  - ap_start=1; a and b held stable.
  - ap_ready=1 and ap_done=1 in the same cycle: capture ap_return, go to RESULT.
  - ap_ready=1 without ap_done: go to WAIT.
  - ap_done=1 without ap_ready: capture ap_return, stay in START until ap_ready. The late ap_ready is not a new result.
  - Otherwise stay in START.
- WAIT:
  - ap_start=0.
  - On ap_done=1: capture ap_return, go to RESULT.
- RESULT:
  - out_valid=1; out_data and out_timeout are stable.
  - When out_ready is high: go to IDLE.
- in_ready is high only in IDLE. Exactly one transaction is outstanding at a time.
- a and b change only on IDLE acceptance. They keep their last value in all other states.
- ap_return is sampled only in a cycle where ap_done=1 and the FSM is in START or WAIT. ap_done in any other state is ignored.
- Reset values: state IDLE, ap_start 0, out_valid 0, out_data 0, out_timeout 0, a 0, b 0. in_ready is 1 from the first cycle after reset.
- Reset mid-transaction: ap_start drops at the next edge and the pending result is discarded. The attached core is reset from the same ap_rst_n.

## Timing

- Combinational core (ap_done=ap_ready=ap_start in the same cycle):
  - Accept at cycle N, ap_start high in N+1, capture at the end of N+1.
  - out_valid high in N+2.
  - Peak throughput is one result per 3 cycles with out_ready tied high.
- Multi-cycle core: out_valid asserts 1 cycle after the ap_done cycle.
- All outputs are registered. There is no combinational path from the core's inputs to the driver's outputs except in_ready, which is decoded from the FSM state only.

## Configuration

- `ALU_DRV_TIMEOUT_EN` defined:
  - Watchdog counts cycles spent in START and WAIT, starting from entry to START.
  - Reaching TIMEOUT_CYC without a capture: ap_start=0, out_data=0, out_timeout=1, go to RESULT.
  - A capture in the same cycle as expiry wins: normal result, out_timeout=0.
- Macro undefined:
  - No counter is built; the driver waits indefinitely.
  - out_timeout is tied to 0 and the port is kept for interface stability.

## Structure

- Package alu_drv_pkg:
  - State enum drv_state_t {IDLE, START, WAIT, RESULT}.
  - DATA_W default constant.
  - Watchdog counter width: 16 bits.
- One sub-module, alu_drv_watchdog:
  - Inputs: clear, enable. Output: expired.
  - Instantiated only under `ALU_DRV_TIMEOUT_EN`.

## Test plan

- Combinational core model, in_a=5, in_b=7, core returns a+b, out_ready=1 → ap_start high for exactly 1 cycle; out_valid in cycle N+2 with out_data=12, out_timeout=0.
- Core with ap_ready 1 cycle after start and ap_done 4 cycles after start → ap_start high for 2 cycles; out_valid 1 cycle after ap_done with the correct ap_return value.
- out_ready held low for 10 cycles with in_valid high → in_ready=0 and out_data stable throughout; ap_start stays 0; the next operand is accepted only after out_ready=1.
- Core never asserts ap_done, TIMEOUT_CYC=8, macro defined → ap_start=0 after 8 cycles; out_valid=1 with out_data=0 and out_timeout=1. With the macro undefined, no out_valid appears over 1000 cycles.
- ap_rst_n=0 asserted while in WAIT → after the next edge: ap_start=0, out_valid=0, in_ready=1; a later ap_done is ignored.
- Back-to-back transactions with a random-latency core over 1000 operand pairs → every result is in order and matches the reference model; ap_start never rises while out_valid=1.
